// File: rtl/shift_sequencer_if.sv
// Request, shifter-drive and result signals of the shift sequencer.
// slave: the sequencer; master: the surrounding core (request source,
// shifter and writeback consumer).
interface shift_sequencer_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SBITS = 3
) ();
   localparam int unsigned SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_val;
   logic [SHW-1:0]   in_shamt;
   logic             in_right;
   logic             in_arith;

   logic [WIDTH-1:0] sh_val;
   logic [SBITS-1:0] sh_sham;
   logic             sh_right;
   logic             sh_arith;
   logic [WIDTH-1:0] sh_out;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport slave (
      input  in_valid, in_val, in_shamt, in_right, in_arith, sh_out, out_ready,
      output in_ready, sh_val, sh_sham, sh_right, sh_arith, out_valid, out_data
   );

   modport master (
      output in_valid, in_val, in_shamt, in_right, in_arith, sh_out, out_ready,
      input  in_ready, sh_val, sh_sham, sh_right, sh_arith, out_valid, out_data
   );
endinterface

// File: rtl/shift_sequencer.sv
// Breaks a full-width shift into steps of at most 2^SBITS positions, driving a
// narrow external barrel shifter (BIAS=1) and accumulating its output.
module shift_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SBITS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kill,
   shift_sequencer_if.slave  bus
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam logic [SHW:0] STEP_MAX = (SHW + 1)'(2 ** SBITS);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW:0]     rem_q, rem_d;
   logic             right_q, right_d;
   logic             arith_q, arith_d;
   logic [SHW:0]     step;
   logic [SHW:0]     step_m1;
   logic [SHW:0]     rem_next;

   // Step size for the current RUN cycle and the remainder after it.
   always_comb begin
      step     = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;
      step_m1  = step - (SHW + 1)'(1);
      rem_next = rem_q - step;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         rem_q   <= '0;
         right_q <= 1'b0;
         arith_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         right_q <= right_d;
         arith_q <= arith_d;
      end
   end

   // Next-state, datapath update and outputs.
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      rem_d         = rem_q;
      right_d       = right_q;
      arith_d       = arith_q;
      bus.in_ready  = (state_q == StIdle) & ~kill;
      bus.sh_val    = acc_q;
      bus.sh_sham   = '0;
      bus.sh_right  = right_q;
      bus.sh_arith  = arith_q;
      bus.out_valid = (state_q == StDone);
      bus.out_data  = acc_q;

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid && bus.in_ready) begin
               acc_d   = bus.in_val;
               rem_d   = {1'b0, bus.in_shamt};
               right_d = bus.in_right;
               // Left shifts never sign-fill.
               arith_d = bus.in_right & bus.in_arith;
               state_d = (bus.in_shamt == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            bus.sh_sham = step_m1[SBITS-1:0];
            acc_d       = bus.sh_out;
            rem_d       = rem_next;
            if (rem_next == '0) state_d = StDone;
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Flush overrides everything, including a held result.
      if (kill) state_d = StIdle;
   end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural BIAS=1 shifter.
module tb_shift_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic kill = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   amt;

   shift_sequencer_if #(.WIDTH(32), .SBITS(3)) bus ();

   shift_sequencer #(.WIDTH(32), .SBITS(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .kill (kill),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Downstream shifter: shifts sh_val by sh_sham+1.
   always_comb begin
      amt = int'(bus.sh_sham) + 1;
      if (!bus.sh_right)     bus.sh_out = bus.sh_val << amt;
      else if (bus.sh_arith) bus.sh_out = $signed(bus.sh_val) >>> amt;
      else                   bus.sh_out = bus.sh_val >> amt;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, check the sh_sham sequence, latency and result.
   // Leaves the block in DONE (out_ready low) for the caller to complete.
   task automatic do_req(input string tag, input logic [31:0] val, input logic [4:0] shamt,
                         input logic right, input logic arith, input int exp_n,
                         input logic [11:0] exp_seq, input logic [31:0] exp_data);
      int lat;
      int n;
      bus.in_valid = 1'b1;
      bus.in_val   = val;
      bus.in_shamt = shamt;
      bus.in_right = right;
      bus.in_arith = arith;
      #1;
      check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      next_cycle();
      bus.in_valid = 1'b0;
      lat = 1;
      n   = 0;
      while (bus.out_valid !== 1'b1 && lat < 12) begin
         if (n < exp_n)
            check_eq($sformatf("%s_sham%0d", tag, n), 32'(bus.sh_sham), 32'(exp_seq[3*n +: 3]));
         n++;
         next_cycle();
         lat++;
      end
      check_eq({tag, "_latency"}, 32'(lat), 32'(exp_n + 1));
      check_eq({tag, "_runs"}, 32'(n), 32'(exp_n));
      check_eq({tag, "_data"}, bus.out_data, exp_data);
   endtask

   task automatic finish_req(input string tag);
      bus.out_ready = 1'b1;
      next_cycle();
      bus.out_ready = 1'b0;
      check_eq({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic seen_valid;
      bus.in_valid  = 1'b0;
      bus.in_val    = '0;
      bus.in_shamt  = '0;
      bus.in_right  = 1'b0;
      bus.in_arith  = 1'b0;
      bus.out_ready = 1'b0;

      #2;
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_data", bus.out_data, 32'd0);
      check_eq("rst_sh_val", bus.sh_val, 32'd0);
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #11 rst = 1'b0;
      next_cycle();

      do_req("sll31", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 4, 12'hDFF, 32'h8000_0000);
      finish_req("sll31");
      do_req("sra20", 32'h8000_0000, 5'd20, 1'b1, 1'b1, 3, 12'h0FF, 32'hFFFF_F800);
      finish_req("sra20");
      do_req("srl8", 32'hF000_000F, 5'd8, 1'b1, 1'b0, 1, 12'h007, 32'h00F0_0000);
      finish_req("srl8");
      do_req("sll4a", 32'h8000_0001, 5'd4, 1'b0, 1'b1, 1, 12'h003, 32'h0000_0010);
      finish_req("sll4a");
      do_req("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 0, 12'h000, 32'hDEAD_BEEF);
      finish_req("zero");

      // Backpressure: hold the result, then handshake with the next request pending.
      do_req("bp", 32'h1234_5678, 5'd4, 1'b1, 1'b0, 1, 12'h003, 32'h0123_4567);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check_eq($sformatf("bp_hold_data%0d", i), bus.out_data, 32'h0123_4567);
         check_eq($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
         check_eq($sformatf("bp_hold_rdy%0d", i), 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b1;
      bus.in_val    = 32'h0000_0001;
      bus.in_shamt  = 5'd1;
      bus.in_right  = 1'b0;
      bus.in_arith  = 1'b0;
      finish_req("bp");
      do_req("bp_next", 32'h0000_0001, 5'd1, 1'b0, 1'b0, 1, 12'h000, 32'h0000_0002);
      finish_req("bp_next");

      // Kill in the 2nd RUN cycle of a 31-bit shift.
      bus.in_valid = 1'b1;
      bus.in_val   = 32'h0000_0001;
      bus.in_shamt = 5'd31;
      bus.in_right = 1'b0;
      next_cycle();
      bus.in_valid = 1'b0;
      next_cycle();
      kill = 1'b1;
      #1;
      check_eq("kill_in_ready_low", 32'(bus.in_ready), 32'd0);
      next_cycle();
      kill = 1'b0;
      #1;
      check_eq("kill_in_ready_next", 32'(bus.in_ready), 32'd1);
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.out_valid === 1'b1) seen_valid = 1'b1;
         next_cycle();
      end
      check_eq("kill_no_valid", 32'(seen_valid), 32'd0);

      // Kill together with in_valid: nothing may be accepted.
      kill         = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_shamt = 5'd0;
      #1;
      check_eq("kill_req_rdy", 32'(bus.in_ready), 32'd0);
      next_cycle();
      kill         = 1'b0;
      bus.in_valid = 1'b0;
      check_eq("kill_req_not_taken", 32'(bus.out_valid), 32'd0);
      next_cycle();
      check_eq("kill_req_not_taken2", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset in the middle of RUN.
      bus.in_valid = 1'b1;
      bus.in_val   = 32'h8000_0000;
      bus.in_shamt = 5'd31;
      bus.in_right = 1'b1;
      bus.in_arith = 1'b1;
      next_cycle();
      bus.in_valid = 1'b0;
      next_cycle();
      check_eq("pre_rst_sh_sham", 32'(bus.sh_sham), 32'd7);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_sh_val", bus.sh_val, 32'd0);
      check_eq("arst_sh_sham", 32'(bus.sh_sham), 32'd0);
      check_eq("arst_sh_right", 32'(bus.sh_right), 32'd0);
      check_eq("arst_sh_arith", 32'(bus.sh_arith), 32'd0);
      check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("arst_out_data", bus.out_data, 32'd0);
      check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
      #3 rst = 1'b0;
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle control stage that sits directly upstream of the narrow barrel `shifter` in the microcoded core. It accepts a full RV32 shift request (SLL/SRL/SRA, shift amount 0..WIDTH-1) and breaks it into a series of bounded steps of at most 2^SBITS positions. It drives the shifter each cycle and feeds the shifter's output back into an accumulator. The final result goes to the writeback stage over a valid/ready handshake.

## Interface
- WIDTH, 32, datapath width; must be a power of two ≥ 2^SBITS
- SBITS, 3, shifter amount field width; the connected shifter is instantiated with BIAS=1, so one step covers 1..2^SBITS positions
- SHW, $clog2(WIDTH), derived localparam: request shift-amount width
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous and active-high
- kill  input  1  synchronous abort (pipeline flush)
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid & in_ready
- in_val  input  WIDTH  operand to shift
- in_shamt  input  SHW  shift amount
- in_right  input  1  1 = right shift, 0 = left
- in_arith  input  1  arithmetic fill; only meaningful with in_right=1
- sh_val  output  WIDTH  shifter operand (the accumulator)
- sh_sham  output  SBITS  shifter amount field; step = sh_sham+1
- sh_right  output  1  to shifter right_shift
- sh_arith  output  1  to shifter arith_shift
- sh_out  input  WIDTH  shifter result, combinational from sh_*
- out_valid  output  1  result valid
- out_ready  input  1  consumer ready
- out_data  output  WIDTH  shift result

## Operation
- Datapath registers:
  - acc (WIDTH)
  - rem (SHW+1), the remaining shift amount
  - right, arith flags
- FSM states are IDLE, RUN and DONE.
- in_ready = (state==IDLE) & ~kill. It is combinational and drives no registers.
- **IDLE.** On accept, the block loads acc←in_val, rem←in_shamt, right←in_right and arith←in_right&in_arith (a left shift never uses arith fill).
  - If in_shamt==0, go to DONE. Otherwise go to RUN.
- **RUN.** Each cycle, step = min(rem, 2^SBITS).
  - Outputs: sh_sham = step-1, sh_val = acc, sh_right = right, sh_arith = arith.
  - Edge update: acc←sh_out, rem←rem-step.
  - If rem-step==0, go to DONE.
- **DONE.** out_valid=1 and out_data=acc. On out_ready, go to IDLE.
- Outside RUN, sh_sham=0 and sh_val/sh_right/sh_arith show the current registers. The consumer must ignore sh_out in those states.
- Arithmetic right shift stays correct across steps because acc[WIDTH-1] holds the sign after every step.
- **kill.** In any state, the next state is IDLE, and out_valid drops the cycle after. Any result being held in DONE is discarded.
  - A kill in the same cycle as in_valid means nothing is accepted, because in_ready is 0.
  - A kill in DONE in the same cycle as out_ready counts as a completed handshake; the state is IDLE either way.
- out_data is held stable for as long as out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - state = IDLE; acc, rem, right, arith = 0
  - out_valid = 0, out_data = 0
  - sh_val = 0, sh_sham = 0, sh_right = 0, sh_arith = 0
  - in_ready = 1 whenever kill=0
- Latency: define cycle 0 as the accept edge. RUN takes N = ceil(shamt/2^SBITS) cycles, and out_valid is first high in cycle N+1.
  - shamt=0 gives out_valid in cycle 1.
  - shamt=31 gives N=4, with step sequence 8, 8, 8, 7.
- Throughput: at most one request in flight. With out_ready held high, the next accept can happen in the cycle after the DONE handshake.
- rst mid-operation forces the reset values at once, without waiting for a clock edge.

## Test plan
- SLL in_val=0x0000_0001, shamt=31 -> sh_sham sequence 7, 7, 7, 6; out_data=0x8000_0000; out_valid in cycle 5.
- SRA in_val=0x8000_0000, shamt=20 -> three RUN cycles (sh_sham 7, 7, 3); out_data=0xFFFF_F800.
- SRL in_val=0xF000_000F, shamt=8 -> one RUN cycle with sh_sham=7; out_data=0x00F0_0000. Repeat with in_arith=1 and in_right=0, shamt=4, in_val=0x8000_0001 -> out_data=0x0000_0010 (arith ignored on left shift).
- shamt=0 with in_val=0xDEAD_BEEF -> no RUN cycles; out_valid in cycle 1 with out_data=0xDEAD_BEEF.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_data stays stable and in_ready=0. Raise out_ready with a new in_valid already pending -> the new request is accepted exactly one cycle after the handshake.
- kill asserted in the 2nd RUN cycle of a shamt=31 request -> out_valid never rises, and in_ready=1 the next cycle. In a separate run, assert rst in the middle of RUN -> every output at its reset value immediately.
